// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates four byte-stream requesters onto a single uart_tx.
// A requester that presents a byte with req_last=0 locks the arbiter so that
// its whole packet goes out before anyone else is granted.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req_vld   per-requester byte valid (bit i = requester i)
//   req_data  requester i byte in bits [8i+7:8i]
//   req_last  bit i high = byte i ends requester i's packet
//   req_ack   one-hot one-cycle accept pulse
//   owner     index of the most recently granted requester
//   busy      high whenever the FSM is not idle
//   tx_start  one-cycle start pulse to uart_tx
//   tx_data   byte to uart_tx, held until the next accept
//   tx_rdy    uart_tx idle/ready
//
// Build option: define UART_TX_ARB_RR_EN for round-robin selection among
// unlocked requesters; otherwise selection is fixed priority (lowest wins).

module uart_tx_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_vld,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ack,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy
);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e      state_q;
  logic        lock_q;
  logic [3:0]  req_ack_q;
  logic [1:0]  owner_q;
  logic        busy_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
`ifdef UART_TX_ARB_RR_EN
  logic [1:0]  ptr_q;
  logic [1:0]  cand;
`endif

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [7:0]  win_data;
  logic        win_last;

  // Winner selection. While locked only the current owner may be granted.
  always_comb begin
    win_idx = owner_q;
    win_vld = req_vld[owner_q];
`ifdef UART_TX_ARB_RR_EN
    cand    = ptr_q;
`endif
    if (!lock_q) begin
      win_vld = |req_vld;
`ifdef UART_TX_ARB_RR_EN
      win_idx = ptr_q;
      // Scan from the farthest offset down so the nearest one after ptr wins.
      for (int i = 3; i >= 0; i--) begin
        cand = ptr_q + 2'(i);
        if (req_vld[cand]) win_idx = cand;
      end
`else
      for (int i = 3; i >= 0; i--) begin
        if (req_vld[i]) win_idx = 2'(i);
      end
`endif
    end
    win_data = req_data[{win_idx, 3'b000} +: 8];
    win_last = req_last[win_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lock_q     <= 1'b0;
      req_ack_q  <= 4'b0000;
      owner_q    <= 2'd0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef UART_TX_ARB_RR_EN
      ptr_q      <= 2'd0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      req_ack_q  <= 4'b0000;
      case (state_q)
        StIdle: begin
          if (tx_rdy && win_vld) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= win_data;
            req_ack_q  <= 4'b0001 << win_idx;
            owner_q    <= win_idx;
            lock_q     <= ~win_last;
            busy_q     <= 1'b1;
            state_q    <= StWaitBusy;
`ifdef UART_TX_ARB_RR_EN
            if (win_last) ptr_q <= win_idx + 2'd1;
`endif
          end
        end
        // Wait for uart_tx to report it has picked up the byte.
        StWaitBusy: begin
          if (!tx_rdy) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (tx_rdy) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack  = req_ack_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
